// File: rtl/stage4_memwb.sv
// Memory-access / write-back stage: IDLE -> (REQ) -> WB -> DONE sequencer with a captured operand set.
// Optional REQ timeout is enabled by defining STAGE4_TIMEOUT_EN.
module stage4_memwb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Start,
    input  logic [DATA_W-1:0] ResIn,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [1:0]        MemOp,
    input  logic [3:0]        DestReg,
    output logic              MemReq,
    output logic              MemWE,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemRData,
    output logic              RegWrite,
    output logic [3:0]        RegWAddr,
    output logic [DATA_W-1:0] RegWData,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [1:0] {IDLE, REQ, WB, DONE} state_t;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        op_q, op_d;
    logic [3:0]        dest_q, dest_d;
    logic              err_q, err_d;
    logic              timeout_hit;

`ifdef STAGE4_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Hit when this REQ cycle would be the TIMEOUT-th one without an ack.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT is inert without the counter.
    assign timeout_hit = (TIMEOUT == 0) & 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        dest_d  = dest_q;
        err_d   = err_q;
`ifdef STAGE4_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    addr_d  = ResIn;
                    wdata_d = StoreData;
                    dest_d  = DestReg;
                    op_d    = (MemOp == 2'b11) ? OP_NONE : MemOp;
                    err_d   = 1'b0;
`ifdef STAGE4_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = (MemOp == OP_LOAD || MemOp == OP_STORE) ? REQ : WB;
                end
            end
            REQ: begin
                if (MemAck) begin
                    if (op_q == OP_LOAD) begin
                        rdata_d = MemRData;
                        state_d = WB;
                    end else begin
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
`ifdef STAGE4_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            WB:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            err_q   <= 1'b0;
`ifdef STAGE4_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
`ifdef STAGE4_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // All outputs decode registered state only, so MemAck has no combinational path out.
    assign MemReq   = (state_q == REQ);
    assign MemWE    = MemReq && (op_q == OP_STORE);
    assign MemAddr  = MemReq ? addr_q : '0;
    assign MemWData = MemReq ? wdata_q : '0;
    assign RegWrite = (state_q == WB);
    assign RegWAddr = RegWrite ? dest_q : '0;
    assign RegWData = RegWrite ? ((op_q == OP_LOAD) ? rdata_q : addr_q) : '0;
    assign Busy     = (state_q != IDLE);
    assign Done     = (state_q == DONE);
    assign Error    = err_q;

endmodule

// File: tb/tb_stage4_memwb.sv
// Self-checking bench for stage4_memwb: directed table, reset/timeout sequences, random transactions.
module tb_stage4_memwb;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    logic          CLK, RST_N, Start, MemAck;
    logic [DW-1:0] ResIn, StoreData, MemRData;
    logic [1:0]    MemOp;
    logic [3:0]    DestReg;
    logic          MemReq, MemWE, RegWrite, Busy, Done, Error;
    logic [DW-1:0] MemAddr, MemWData, RegWData;
    logic [3:0]    RegWAddr;

    stage4_memwb #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .ResIn(ResIn), .StoreData(StoreData),
        .MemOp(MemOp), .DestReg(DestReg), .MemReq(MemReq), .MemWE(MemWE),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
        .RegWrite(RegWrite), .RegWAddr(RegWAddr), .RegWData(RegWData),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit err_prev = 1'b0;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] resin, sdata, rdata;
        logic [3:0]  dest;
        int unsigned waits;
        bit          exp_rw;
        logic [15:0] exp_rwdata;
        int unsigned exp_done;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] resin, input logic [15:0] sdata,
                                input logic [15:0] rdata, input logic [3:0] dest, input int unsigned waits,
                                input bit rw, input logic [15:0] rwdata, input int unsigned done, input bit err);
        vec_t v;
        v.op = op; v.resin = resin; v.sdata = sdata; v.rdata = rdata; v.dest = dest; v.waits = waits;
        v.exp_rw = rw; v.exp_rwdata = rwdata; v.exp_done = done; v.exp_err = err;
        return v;
    endfunction

    // Reference: cycle of Done counted from the Start edge, derived from the operation rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit   is_mem = (v.op == 2'b01) || (v.op == 2'b10);
        r.exp_err = 1'b0;
        if (!is_mem) begin
            r.exp_rw = 1'b1; r.exp_rwdata = v.resin; r.exp_done = 2;
        end else begin
`ifdef STAGE4_TIMEOUT_EN
            if (v.waits + 1 > TO) begin
                r.exp_rw = 1'b0; r.exp_rwdata = '0; r.exp_done = TO + 1; r.exp_err = 1'b1;
                return r;
            end
`endif
            if (v.op == 2'b01) begin
                r.exp_rw = 1'b1; r.exp_rwdata = v.rdata; r.exp_done = v.waits + 3;
            end else begin
                r.exp_rw = 1'b0; r.exp_rwdata = '0; r.exp_done = v.waits + 2;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".memreq"}, MemReq, 0);   chk({tag, ".memwe"}, MemWE, 0);
        chk({tag, ".memaddr"}, MemAddr, 0); chk({tag, ".memwdata"}, MemWData, 0);
        chk({tag, ".regwrite"}, RegWrite, 0); chk({tag, ".regwaddr"}, RegWAddr, 0);
        chk({tag, ".regwdata"}, RegWData, 0); chk({tag, ".busy"}, Busy, 0);
        chk({tag, ".done"}, Done, 0);       chk({tag, ".error"}, Error, 0);
    endtask

    task automatic apply_reset(input string tag);
        RST_N = 1'b0; Start = 1'b0; MemAck = 1'b0;
        tick();
        check_all_zero(tag);
        RST_N = 1'b1;
        err_prev = 1'b0;
    endtask

    // Drives one transaction from IDLE and checks every output each cycle until back in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        bit          is_mem = (v.op == 2'b01) || (v.op == 2'b10);
        int unsigned n_req  = !is_mem ? 0 : (v.exp_err ? TO : v.waits + 1);
        chk({tag, ".idle_busy"}, Busy, 0);
        chk({tag, ".idle_err"}, Error, err_prev);
        Start = 1'b1; ResIn = v.resin; StoreData = v.sdata; MemOp = v.op; DestReg = v.dest;
        MemAck = 1'($urandom_range(0, 1)); MemRData = 16'($urandom);
        tick();
        for (int unsigned c = 1; c <= v.exp_done + 1; c++) begin
            bit in_req = (c <= n_req);
            bit rw_now = v.exp_rw && (c == v.exp_done - 1);
            chk({tag, ".memreq"}, MemReq, in_req);
            chk({tag, ".memwe"}, MemWE, in_req && (v.op == 2'b10));
            if (in_req) begin
                chk({tag, ".memaddr"}, MemAddr, v.resin);
                chk({tag, ".memwdata"}, MemWData, v.sdata);
            end
            chk({tag, ".regwrite"}, RegWrite, rw_now);
            if (rw_now) begin
                chk({tag, ".regwaddr"}, RegWAddr, v.dest);
                chk({tag, ".regwdata"}, RegWData, v.exp_rwdata);
            end
            chk({tag, ".done"}, Done, c == v.exp_done);
            chk({tag, ".busy"}, Busy, c <= v.exp_done);
            chk({tag, ".error"}, Error, v.exp_err && (c >= v.exp_done));
            // Scramble inputs after capture; Start only while busy, where it must be ignored.
            Start = (c <= v.exp_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            ResIn = 16'($urandom); StoreData = 16'($urandom); MemOp = 2'($urandom); DestReg = 4'($urandom);
            if (in_req) begin
                MemAck   = !v.exp_err && (c == n_req);
                MemRData = MemAck ? v.rdata : 16'($urandom);
            end else begin
                MemAck   = 1'($urandom_range(0, 1));
                MemRData = 16'($urandom);
            end
            tick();
        end
        Start = 1'b0; MemAck = 1'b0;
        err_prev = v.exp_err;
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; Start = 1'b0; MemAck = 1'b0; ResIn = '0; StoreData = '0;
        MemOp = '0; DestReg = '0; MemRData = '0;
        tick();
        apply_reset("reset");

        tbl.push_back(mk(2'b00, 16'h1234, 16'h0000, 16'h0000, 4'd5,  0, 1'b1, 16'h1234, 2, 1'b0));
        tbl.push_back(mk(2'b01, 16'h0040, 16'h1111, 16'hBEEF, 4'd9,  3, 1'b1, 16'hBEEF, 6, 1'b0));
        tbl.push_back(mk(2'b10, 16'h0100, 16'hA5A5, 16'h0000, 4'd3,  0, 1'b0, 16'h0000, 2, 1'b0));
        tbl.push_back(mk(2'b11, 16'h7777, 16'h2222, 16'h0000, 4'd15, 0, 1'b1, 16'h7777, 2, 1'b0));
        tbl.push_back(mk(2'b01, 16'h0002, 16'h0000, 16'h0001, 4'd0,  0, 1'b1, 16'h0001, 3, 1'b0));
        tbl.push_back(mk(2'b10, 16'hFFFF, 16'h5A5A, 16'h0000, 4'd7,  2, 1'b0, 16'h0000, 4, 1'b0));
`ifdef STAGE4_TIMEOUT_EN
        tbl.push_back(mk(2'b10, 16'h0200, 16'hC3C3, 16'h0000, 4'd1, 50, 1'b0, 16'h0000, 5, 1'b1));
        tbl.push_back(mk(2'b00, 16'h0ABC, 16'h0000, 16'h0000, 4'd2,  0, 1'b1, 16'h0ABC, 2, 1'b0));
`endif
        foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a load waits for MemAck; a late ack must not revive it.
        Start = 1'b1; ResIn = 16'h0040; MemOp = 2'b01; DestReg = 4'd6; StoreData = '0;
        tick();
        Start = 1'b0;
        chk("rstreq.memreq_before", MemReq, 1);
        tick();
        apply_reset("rstreq");
        MemAck = 1'b1; MemRData = 16'hDEAD;
        tick();
        chk("rstreq.late_busy", Busy, 0);
        chk("rstreq.late_memreq", MemReq, 0);
        chk("rstreq.late_regwrite", RegWrite, 0);
        MemAck = 1'b0;
        tick();
        run_txn(model(mk(2'b01, 16'h0044, 16'h0, 16'h1357, 4'd6, 1, 1'b0, 16'h0, 0, 1'b0)), "afterrst");

`ifndef STAGE4_TIMEOUT_EN
        // No timeout in this build: request must stay up indefinitely without Error.
        Start = 1'b1; ResIn = 16'h0300; MemOp = 2'b01; DestReg = 4'd4;
        tick();
        Start = 1'b0;
        begin
            int unsigned held = 0;
            for (int k = 0; k < 100; k++) begin
                if (MemReq === 1'b1 && Error === 1'b0) held++;
                tick();
            end
            chk("noto.memreq_held", held, 100);
            chk("noto.error", Error, 0);
        end
        apply_reset("noto.rst");
        tick();
`endif

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.op = 2'($urandom); v.resin = 16'($urandom); v.sdata = 16'($urandom);
            v.rdata = 16'($urandom); v.dest = 4'($urandom); v.waits = $urandom_range(0, 6);
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage4_memwb.md
STAGE4_MEMWB -- requirements
Module: stage4_memwb

Interface
REQ-001 Parameter: DATA_W, 16, width of data, address and result buses.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles spent in REQ before abort; used only when STAGE4_TIMEOUT_EN is defined.
REQ-003 Port: CLK  in  1  single clock; all state changes on rising edge.
REQ-004 Port: RST_N  in  1  reset, synchronous, active-low.
REQ-005 Port: Start  in  1  launch request; sampled only in IDLE.
REQ-006 Port: ResIn  in  DATA_W  stage-3 Res register value (memory address, or result to write back).
REQ-007 Port: StoreData  in  DATA_W  data for store.
REQ-008 Port: MemOp  in  2  operation: 00 none, 01 load, 10 store, 11 treated as 00.
REQ-009 Port: DestReg  in  4  register-file destination.
REQ-010 Port: MemReq, MemWE  out  1 each  memory request and write enable.
REQ-011 Port: MemAddr, MemWData  out  DATA_W each  memory address and write data.
REQ-012 Port: MemAck  in  1  memory completion; MemRData  in  DATA_W  load data, valid with MemAck.
REQ-013 Port: RegWrite  out  1; RegWAddr  out  4; RegWData  out  DATA_W  register-file write port.
REQ-014 Port: Busy  out  1  high in every state except IDLE.
REQ-015 Port: Done  out  1  one-cycle completion pulse.
REQ-016 Port: Error  out  1  timeout flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, REQ, WB and DONE.
REQ-018 IDLE with Start=1 SHALL capture ResIn, StoreData, MemOp and DestReg into internal registers; the next state is WB for op none/11, otherwise REQ.
REQ-019 Input changes after capture SHALL have no effect until the next return to IDLE; Start outside IDLE SHALL be ignored.
REQ-020 In REQ: MemReq=1, MemAddr=captured ResIn, MemWData=captured StoreData, MemWE=1 for store only; all four held stable until MemAck is sampled high.
REQ-021 MemAck sampled high in the first REQ cycle SHALL be accepted (zero-wait memory).
REQ-022 REQ with MemAck=1: load SHALL capture MemRData and go to WB; store SHALL go to DONE with no register write.
REQ-023 MemAck outside REQ SHALL be ignored.
REQ-024 WB SHALL assert RegWrite for exactly one cycle, with RegWAddr=captured DestReg and RegWData=loaded data (load) or captured ResIn (none); next state is DONE.
REQ-025 DONE SHALL assert Done for exactly one cycle, then return to IDLE; Start sampled in DONE is ignored.
REQ-026 Latency, with Start sampled at edge k: op none gives RegWrite in cycle k+1, Done in k+2, IDLE at k+3; for load/store with MemAck sampled at edge m, a load gives RegWrite in m+1 and Done in m+2, and a store gives Done in m+1.
REQ-027 Outputs MemReq, MemWE, RegWrite and Done SHALL be registered-state decodes with no combinational path from MemAck.

Reset
REQ-028 RST_N=0 at an edge SHALL force IDLE, regardless of current state, including mid-REQ.
REQ-029 During reset, all outputs (MemReq, MemWE, MemAddr, MemWData, RegWrite, RegWAddr, RegWData, Busy, Done, Error) and the timeout counter SHALL be 0 from the next cycle.
REQ-030 A reset in REQ SHALL drop MemReq without waiting for MemAck.

Configuration
REQ-031 With macro STAGE4_TIMEOUT_EN defined: a counter SHALL clear on REQ entry and increment each REQ cycle without MemAck; when it reaches TIMEOUT, the block SHALL leave REQ for DONE with no RegWrite and set Error.
REQ-032 Error SHALL stay set until the next accepted Start or reset; MemAck in the same cycle the counter reaches TIMEOUT SHALL win, giving a normal completion.
REQ-033 Without STAGE4_TIMEOUT_EN: no counter; REQ waits indefinitely; Error is tied to 0.

Verification
REQ-034 Op none: ResIn=0x1234, DestReg=5, Start at edge k -> RegWrite=1 in k+1 with RegWAddr=5 and RegWData=0x1234; Done=1 in k+2; Busy low at k+3.
REQ-035 Load: ResIn=0x0040, MemAck after 3 wait cycles with MemRData=0xBEEF -> MemReq/MemAddr=0x0040 stable during wait; RegWData=0xBEEF, RegWAddr=DestReg one cycle after ack.
REQ-036 Store with zero-wait ack: StoreData=0xA5A5 -> MemWE=1 and MemWData=0xA5A5 for one cycle; Done next cycle; RegWrite never asserted.
REQ-037 RST_N=0 during load wait state -> MemReq=0 and Busy=0 next cycle; a late MemAck is ignored; a subsequent Start works normally.
REQ-038 With STAGE4_TIMEOUT_EN and TIMEOUT=4, no ack -> exactly 4 REQ cycles, Error=1 and Done=1 with no RegWrite; next Start clears Error. Without the macro, the same stimulus holds MemReq high for 100 cycles with Error=0.
